// File: rtl/role_ctrl_pkg.sv
// Shared register map, CTRL bit positions, AXI response codes and FSM state types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package role_ctrl_pkg;

  // Word-aligned register offsets
  localparam logic [31:0] CTRL_OFS = 32'h00;
  localparam logic [31:0] IER_OFS  = 32'h04;
  localparam logic [31:0] ISR_OFS  = 32'h08;
  localparam logic [31:0] ARG_BASE = 32'h10;

  // CTRL register bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Result of decoding one byte address against the register map
  typedef struct packed {
    logic       is_ctrl;
    logic       is_ier;
    logic       is_isr;
    logic       is_arg;
    logic [3:0] arg_idx;
  } dec_t;

  // Merge write data into a word under a byte-enable mask
  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/role_ctrl_if.sv
// AXI4-Lite bundle between the host (master) and the role control block (slave).
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel.
interface role_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/role_ctrl.sv
// AXI4-Lite control/status block for an acceleration core: CTRL, IER, ISR and ARG registers.
// Latency: bvalid one cycle after both AW and W are held; rvalid one cycle after AR handshake.
// Backpressure: one outstanding write and one outstanding read; readies drop while a beat is held or a response waits.
module role_ctrl
  import role_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_ARGS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  role_ctrl_if.slave               s_axil,
  output logic                     ap_start,
  input  logic                     ap_done,
  input  logic                     ap_idle,
  output logic [NUM_ARGS*32-1:0]   args,
  output logic                     irq
);

  // ---------------------------------------------------------------------------
  // Address decode shared by the read and write paths
  // ---------------------------------------------------------------------------
  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t        d;
    logic [31:0] w;
    w = 32'(a) & ~32'h3;
    d = '0;
    d.is_ctrl = (w == CTRL_OFS);
    d.is_ier  = (w == IER_OFS);
    d.is_isr  = (w == ISR_OFS);
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (w == ARG_BASE + 32'(4 * i)) begin
        d.is_arg  = 1'b1;
        d.arg_idx = 4'(i);
      end
    end
    return d;
  endfunction

  function automatic logic mapped(input dec_t d);
    return d.is_ctrl | d.is_ier | d.is_isr | d.is_arg;
  endfunction

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [NUM_ARGS-1:0][31:0] args_q, args_d;
  logic                      ier_q, ier_d;
  logic                      isr_q, isr_d;
  logic                      done_q, done_d;
  logic                      start_q, start_d;

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t          w_state_q;
  logic              aw_got_q, w_got_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  logic              aw_hs, w_hs, wr_exec;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  dec_t              wr_dec;

  // Ready only while idle and the channel's beat is not yet held; low during reset
  assign s_axil.awready = (w_state_q == W_IDLE) && !aw_got_q && !rst;
  assign s_axil.wready  = (w_state_q == W_IDLE) && !w_got_q  && !rst;
  assign aw_hs          = s_axil.awvalid && s_axil.awready;
  assign w_hs           = s_axil.wvalid  && s_axil.wready;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;

  // Pick held or live beats so a write can execute in the cycle the second beat lands
  always_comb begin
    wr_addr = aw_got_q ? aw_addr_q : s_axil.awaddr;
    wr_data = w_got_q  ? w_data_q  : s_axil.wdata;
    wr_strb = w_got_q  ? w_strb_q  : s_axil.wstrb;
    wr_exec = (w_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    wr_dec  = decode(wr_addr);
  end

  // Write FSM: capture AW/W independently, execute, then hold the response until bready
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got_q  <= 1'b1;
            aw_addr_q <= s_axil.awaddr;
          end
          if (w_hs) begin
            w_got_q  <= 1'b1;
            w_data_q <= s_axil.wdata;
            w_strb_q <= s_axil.wstrb;
          end
          if (wr_exec) begin
            w_state_q <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= mapped(wr_dec) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_axil.bready) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_t    r_state_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        rd_ctrl_q;

  logic        ar_hs, rd_done_clr;
  dec_t        rd_dec;
  logic [31:0] rd_word;

  assign s_axil.arready = (r_state_q == R_IDLE) && !rst;
  assign ar_hs          = s_axil.arvalid && s_axil.arready;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  // DONE clears only when the host actually consumes a CTRL read
  assign rd_done_clr    = (r_state_q == R_DATA) && s_axil.rready && rd_ctrl_q;

  // Read mux over current register values, so a same-cycle write is not visible
  always_comb begin
    rd_dec  = decode(s_axil.araddr);
    rd_word = '0;
    if (rd_dec.is_ctrl) begin
      rd_word[CTRL_DONE_BIT] = done_q;
      rd_word[CTRL_IDLE_BIT] = ap_idle;
    end
    if (rd_dec.is_ier) rd_word[0] = ier_q;
    if (rd_dec.is_isr) rd_word[0] = isr_q;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (rd_dec.is_arg && rd_dec.arg_idx == 4'(i)) rd_word = args_q[i];
    end
  end

  // Read FSM: register data on AR accept and hold it until rready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_ctrl_q <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_state_q <= R_DATA;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= mapped(rd_dec) ? RESP_OKAY : RESP_SLVERR;
            rd_ctrl_q <= rd_dec.is_ctrl;
          end
        end
        R_DATA: begin
          if (s_axil.rready) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rd_ctrl_q <= 1'b0;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------

  // Next-state for registers; hardware set events (ap_done) win over host clears
  always_comb begin
    args_d  = args_q;
    ier_d   = ier_q;
    isr_d   = isr_q;
    done_d  = done_q;
    start_d = 1'b0;
    if (wr_exec) begin
      if (wr_dec.is_ctrl && wr_strb[0] && wr_data[CTRL_START_BIT] && ap_idle) start_d = 1'b1;
      if (wr_dec.is_ier && wr_strb[0]) ier_d = wr_data[0];
      if (wr_dec.is_isr && wr_strb[0] && wr_data[0]) isr_d = 1'b0;
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (wr_dec.is_arg && wr_dec.arg_idx == 4'(i)) begin
          args_d[i] = apply_strb(args_q[i], wr_data, wr_strb);
        end
      end
    end
    if (rd_done_clr) done_d = 1'b0;
    if (ap_done) begin
      done_d = 1'b1;
      isr_d  = 1'b1;
    end
  end

  // Register file flops
  always_ff @(posedge clk) begin
    if (rst) begin
      args_q  <= '0;
      ier_q   <= 1'b0;
      isr_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      args_q  <= args_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  assign args     = args_q;
  assign ap_start = start_q;
  assign irq      = isr_q & ier_q;

endmodule

// File: doc/role_ctrl.md
ROLE_CTRL -- requirements
Module: role_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, AXI4-Lite byte-address width.
REQ-002 Parameter NUM_ARGS, default 4, number of 32-bit argument registers (1..12).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 s_axil_aw{valid,ready,addr}  in/out/in  1/1/ADDR_W  write-address channel; the host is the initiator and role_ctrl is the responder.
REQ-006 s_axil_w{valid,ready,data,strb}  in/out/in/in  1/1/32/4  write-data channel.
REQ-007 s_axil_b{valid,ready,resp}  out/in/out  1/1/2  write-response channel.
REQ-008 s_axil_ar{valid,ready,addr}  in/out/in  1/1/ADDR_W  read-address channel.
REQ-009 s_axil_r{valid,ready,data,resp}  out/in/out/out  1/1/32/2  read-data channel.
REQ-010 ap_start  output  1  one-cycle start pulse to the acceleration core.
REQ-011 ap_done  input  1  one-cycle completion pulse from the core.
REQ-012 ap_idle  input  1  level; core is idle.
REQ-013 args  output  NUM_ARGS x 32  argument registers, packed, arg0 in bits [31:0].
REQ-014 irq  output  1  level interrupt = |(ISR & IER).

Function
REQ-015 Register map (word-aligned; addr[1:0] ignored): 0x00 CTRL, 0x04 IER, 0x08 ISR, 0x10+4*i ARG[i].
REQ-016 CTRL: bit0 START (write 1 -> ap_start pulse; reads 0); bit1 DONE (RO, sticky, clear-on-read); bit2 IDLE (RO, = ap_idle); other bits read 0.
REQ-017 IER bit0 done-interrupt enable, RW; ISR bit0 done-interrupt status, set by ap_done, W1C.
REQ-018 ARG[i] RW, byte-enabled per s_axil_wstrb.
REQ-019 Write FSM states W_IDLE, W_RESP: in W_IDLE awready=wready=1; AW and W latched independently, in either order or the same cycle; once both are held, the write executes and the FSM enters W_RESP with bvalid=1; bvalid is held until bready, then the FSM returns to W_IDLE.
REQ-020 Once a channel's beat has been captured, that channel's ready SHALL be 0 until the FSM returns to W_IDLE.
REQ-021 Read FSM states R_IDLE, R_DATA: arready=1 in R_IDLE; on accept, rdata is registered and the FSM enters R_DATA with rvalid=1; rdata/rresp are stable until rready.
REQ-022 Read latency: rvalid asserts the cycle after the AR handshake; write latency: bvalid asserts the cycle after both AW and W are captured.
REQ-023 Unmapped address: writes are discarded, reads return 0; resp=SLVERR (2'b10) in both cases; mapped accesses return OKAY.
REQ-024 START written while ap_idle=0: no ap_start pulse; resp OKAY.
REQ-025 ap_start asserts the cycle after the write executes, for exactly one cycle.
REQ-026 DONE is cleared at the R_DATA handshake of a CTRL read; if ap_done pulses in the same cycle, DONE remains 1 (set wins).
REQ-027 ISR W1C coinciding with ap_done: ISR bit0 remains 1 (set wins).
REQ-028 Read and write FSMs run concurrently and independently; a simultaneous read and write to the same register returns the pre-write value.

Reset
REQ-029 On rst=1: both FSMs go to idle; awready=wready=arready=0 during reset and 1 in the first cycle after it; bvalid=rvalid=0; bresp=rresp=0; rdata=0; ap_start=0; DONE=0; IER=0; ISR=0; all ARG=0; irq=0.
REQ-030 rst mid-transaction aborts the transaction silently; no response is issued.

Structure
REQ-031 Register offsets, CTRL bit indices and the AXI resp codes (OKAY/SLVERR) belong in a shared package, role_ctrl_pkg.
REQ-032 Single module, no sub-modules; the host-facing shell instantiates it alongside role.

Verification
REQ-033 Write ARG0=0xDEADBEEF with AW one cycle before W, then read ARG0 -> bresp=0, rdata=0xDEADBEEF, rresp=0, rvalid the cycle after arvalid&arready.
REQ-034 ap_idle=1, write CTRL=0x1 -> exactly one ap_start pulse one cycle after the write; repeat with ap_idle=0 -> no pulse.
REQ-035 IER=1, ap_done pulse -> ISR=1, irq=1; write ISR=1 -> irq=0; write ISR=1 in the same cycle as ap_done -> ISR stays 1.
REQ-036 Read CTRL after ap_done -> rdata bit1=1; second read -> bit1=0; ap_done on the first read's handshake cycle -> second read bit1=1.
REQ-037 Write ARG1 with wstrb=4'b0010, wdata=0x0000AB00 over 0x11223344 -> ARG1=0x1122AB44.
REQ-038 Read/write 0x3C (unmapped) -> resp=2'b10, rdata=0; hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=0 throughout.
